// File: rtl/hazard_if.sv
// Pipeline-side signal bundle for the hazard controller: hazard inputs from
// the ID/EX/MEM stages and the pipeline-register enables and flushes sent back.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             id_uses_rt;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_write;
  logic             memwb_write;
  logic             stall;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_rs, ifid_rt, id_uses_rt, idex_mem_read, idex_rt,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
           memwb_write, stall, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, id_uses_rt, idex_mem_read, idex_rt,
           ex_branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
           memwb_write, stall, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS pipeline: memory freeze, branch flush,
// load-use stall, memory-wait timeout. Optional statistics under HAZARD_STATS_EN.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave bus_io
);
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_e;

  localparam bit               TIMEOUT_EN  = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             freeze_s, branch_s, load_use_s, rs_hit_s, rt_hit_s;
  logic             pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s;
  logic             exmem_write_s, memwb_write_s, stall_s;

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= {CNT_W{1'b0}};
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Hazard priority, next state and pipeline control outputs
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_write_s = 1'b1;
    memwb_write_s = 1'b1;
    stall_s       = 1'b0;

    // Once waiting, the freeze holds on mem_ready alone: MEM is stuck on that access.
    case (state_q)
      ST_RUN:      freeze_s = bus_io.mem_req && !bus_io.mem_ready;
      ST_MEM_WAIT: freeze_s = !bus_io.mem_ready;
      default:     freeze_s = 1'b0;
    endcase
    branch_s   = !freeze_s && bus_io.ex_branch_taken;
    rs_hit_s   = (bus_io.idex_rt == bus_io.ifid_rs);
    rt_hit_s   = bus_io.id_uses_rt && (bus_io.idex_rt == bus_io.ifid_rt);
    load_use_s = !freeze_s && !bus_io.ex_branch_taken && bus_io.idex_mem_read &&
                 (bus_io.idex_rt != 5'd0) && (rs_hit_s || rt_hit_s);

    if (freeze_s) begin
      state_d = ST_MEM_WAIT;
      if (wait_cnt_q != CNT_MAX) begin
        wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
      if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LIM)) begin
        mem_err_d = 1'b1;
      end else begin
        mem_err_d = mem_err_q;
      end
    end else begin
      state_d    = ST_RUN;
      wait_cnt_d = {CNT_W{1'b0}};
    end

    if (!rst_n) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      ifid_flush_s  = 1'b1;
      idex_flush_s  = 1'b1;
      exmem_write_s = 1'b0;
      memwb_write_s = 1'b0;
    end else if (freeze_s) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      exmem_write_s = 1'b0;
      memwb_write_s = 1'b0;
      stall_s       = 1'b1;
    end else if (branch_s) begin
      ifid_flush_s  = 1'b1;
      idex_flush_s  = 1'b1;
    end else if (load_use_s) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      idex_flush_s  = 1'b1;
      stall_s       = 1'b1;
    end else begin
      stall_s       = 1'b0;
    end
  end

  assign bus_io.pc_write    = pc_write_s;
  assign bus_io.ifid_write  = ifid_write_s;
  assign bus_io.ifid_flush  = ifid_flush_s;
  assign bus_io.idex_flush  = idex_flush_s;
  assign bus_io.exmem_write = exmem_write_s;
  assign bus_io.memwb_write = memwb_write_s;
  assign bus_io.stall       = stall_s;
  assign bus_io.mem_err     = mem_err_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (branch_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign bus_io.stall_cnt = stall_cnt_q;
  assign bus_io.flush_cnt = flush_cnt_q;
`else
  assign bus_io.stall_cnt = {CNT_W{1'b0}};
  assign bus_io.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (MEM_TIMEOUT=4): directed vectors push
// expected outputs, a negedge monitor pops and compares them.
module tb_hazard_controller;
  localparam int CNT_W = 16;
  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_write, stall}
  localparam logic [6:0] NO = 7'b1100110;
  localparam logic [6:0] LU = 7'b0001111;
  localparam logic [6:0] BR = 7'b1111110;
  localparam logic [6:0] FZ = 7'b0000001;
  localparam logic [6:0] RS = 7'b0011000;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string            name;
    logic [6:0]       flags;
    logic             err;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   m_sc;
  int   m_fc;

  hazard_if #(.CNT_W(CNT_W)) hz ();

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string nm, input logic [6:0] fl, input logic er);
    exp_t e;
    e.name  = nm;
    e.flags = fl;
    e.err   = er;
    e.sc    = STATS ? CNT_W'(m_sc) : {CNT_W{1'b0}};
    e.fc    = STATS ? CNT_W'(m_fc) : {CNT_W{1'b0}};
    exp_q.push_back(e);
    if (fl[0]) m_sc++;
    if (fl == BR) m_fc++;
  endtask

  task automatic step(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses, input logic memrd, input logic [4:0] exrt,
                      input logic br, input logic mreq, input logic mrdy,
                      input logic [6:0] fl, input logic er);
    @(posedge clk);
    #1;
    rst_n              = 1'b1;
    hz.ifid_rs         = rs;
    hz.ifid_rt         = rt;
    hz.id_uses_rt      = uses;
    hz.idex_mem_read   = memrd;
    hz.idex_rt         = exrt;
    hz.ex_branch_taken = br;
    hz.mem_req         = mreq;
    hz.mem_ready       = mrdy;
    push_exp(nm, fl, er);
  endtask

  task automatic reset_chk(input string nm);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_sc  = 0;
    m_fc  = 0;
    push_exp(nm, RS, 1'b0);
  endtask

  // Monitor: compare every cycle that has a pending expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = exp_q.pop_front();
      got = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush,
             hz.exmem_write, hz.memwb_write, hz.stall, hz.mem_err};
      n_checks++;
      if (got !== {e.flags, e.err}) begin
        n_fail++;
        $display("FAIL %s: ctrl got %b want %b", e.name, got, {e.flags, e.err});
      end
      n_checks++;
      if ({hz.stall_cnt, hz.flush_cnt} !== {e.sc, e.fc}) begin
        n_fail++;
        $display("FAIL %s_cnt: stall/flush got %0d/%0d want %0d/%0d",
                 e.name, hz.stall_cnt, hz.flush_cnt, e.sc, e.fc);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_sc     = 0;
    m_fc     = 0;
    rst_n    = 1'b0;
    hz.ifid_rs = 5'd0; hz.ifid_rt = 5'd0; hz.id_uses_rt = 1'b0;
    hz.idex_mem_read = 1'b0; hz.idex_rt = 5'd0; hz.ex_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    reset_chk("reset");
    step("t1_lu",       5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, LU, 1'b0);
    step("t1_bubble",   5'd8, 5'd3, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, NO, 1'b0);
    step("t2_rt0",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NO, 1'b0);
    step("t2_nouse",    5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, NO, 1'b0);
    step("t3_br_lu",    5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, BR, 1'b0);
    step("t3_after",    5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, NO, 1'b0);
    for (int i = 0; i < 3; i++)
      step("t4_frz",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FZ, 1'b0);
    step("t4_exit",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NO, 1'b0);
    step("t6_counts",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NO, 1'b0);
    step("lu_rt_use",   5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LU, 1'b0);
    step("frz_br",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, FZ, 1'b0);
    step("frz_br_exit", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, BR, 1'b0);
    step("rdy_first",   5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, LU, 1'b0);
    step("idle",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NO, 1'b0);
    for (int i = 0; i < 4; i++)
      step("t5_wait",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FZ, 1'b0);
    for (int i = 0; i < 2; i++)
      step("t5_err",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FZ, 1'b1);
    step("t5_exit",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NO, 1'b1);
    step("t5_sticky",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NO, 1'b1);
    for (int i = 0; i < 2; i++)
      step("t6_wait",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FZ, 1'b1);
    reset_chk("t6_mid_rst");
    step("t6_post_rst", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NO, 1'b0);
    for (int i = 0; i < 3; i++)
      step("t6_rewait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FZ, 1'b0);
    step("t6_reexit",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NO, 1'b0);

    repeat (3) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
